core_pipe_ctrl: RTL and testbench
=================================

Name: core_pipe_ctrl

Overview:
Parametrised pipeline control unit for the RV32I core. It tracks per-stage valid bits for an N-stage in-order pipeline and generates per-stage register enables. It also produces load-use stalls, branch-redirect flushes, global memory freezes and EX-operand forwarding selects. It sits beside the stage modules (fetch, decode, execute, load/store, write-back), takes hazard information from them and drives their enables.

Parameters:
NUM_STAGES, 5, pipeline depth; stage 0=IF, 1=ID, 2=EX, NUM_STAGES-1=WB; legal range 4..8
REG_ADDR_W, 5, register index width
LOAD_STAGE, 3, stage at whose end load data becomes available; legal range 3..NUM_STAGES-2
FLUSH_STAGE, 2, stage issuing redirects; stages 0..FLUSH_STAGE are squashed; legal range 1..LOAD_STAGE-1
SEL_W, $clog2(NUM_STAGES), forwarding select width (derived)

Ports:
clk  in  1  core clock
rstn  in  1  reset, synchronous, active-high (rstn=1 resets)
if_valid_i  in  1  fetch presents a valid instruction
mem_stall_i  in  1  memory not ready; freeze the whole pipe
redirect_i  in  1  taken branch/jump resolved in FLUSH_STAGE
id_rs1_i, id_rs2_i  in  REG_ADDR_W each  ID source registers
id_rs_use_i  in  2  ID reads rs1 (bit0) / rs2 (bit1)
ex_rs1_i, ex_rs2_i  in  REG_ADDR_W each  EX source registers
st_rd_i  in  NUM_STAGES*REG_ADDR_W  destination register per stage (slot k = stage k)
st_we_i  in  NUM_STAGES  per-stage register write enable
st_ld_i  in  NUM_STAGES  per-stage "is load"
st_valid_o  out  NUM_STAGES  registered valid per stage
st_en_o  out  NUM_STAGES  enable of the pipeline register feeding stage k (bit0 = PC/IF)
fwd_rs1_o, fwd_rs2_o  out  SEL_W each  0 = register file, k = forward from stage k
ld_use_stall_o  out  1  load-use stall active this cycle

Behaviour:
- Reset (rstn=1 at posedge): st_valid_o=0. Combinational outputs follow from this.
- Next-state precedence, evaluated per cycle: reset > mem_stall > redirect > load-use stall > normal advance.
- Normal advance:
  - valid[0] <= if_valid_i.
  - valid[k] <= valid[k-1].
  - st_en_o all 1.
- mem_stall_i=1:
  - st_en_o=0 and all valids hold.
  - redirect_i and the load-use stall are not acted on. The redirect source holds redirect_i until a non-stalled cycle.
  - ld_use_stall_o still reflects the combinational hazard.
- Load-use hazard (combinational):
  - Condition: valid[1] and id_rs_use_i[b], with ID's rs equal to st_rd_i[j] and st_rd_i[j]!=0.
  - Stage j must satisfy valid[j], st_we_i[j], st_ld_i[j], and 2<=j<=LOAD_STAGE-1.
  - Effect: st_en_o[0], st_en_o[1] = 0; valid[0], valid[1] hold; valid[2] <= 0 (bubble); stages >=3 advance.
  - Repeats each cycle until clear. 1-cycle penalty for the defaults.
- Redirect (not mem-stalled):
  - valid[0..FLUSH_STAGE] <= 0; stages >FLUSH_STAGE advance; st_en_o all 1.
  - Overrides a simultaneous load-use stall: ld_use_stall_o still asserted, enables not gated.
- Forwarding (combinational, EX operands):
  - fwd_rsX_o = smallest k in LOAD_STAGE..NUM_STAGES-1 with valid[k], st_we_i[k], st_rd_i[k]==ex_rsX_i and ex_rsX_i!=0.
  - If that stage k==LOAD_STAGE and st_ld_i[k]=1, select is 0: this is illegal and covered by an assertion.
  - Otherwise 0. Youngest producer wins.
- Stages between EX and LOAD_STAGE, i.e. 3..LOAD_STAGE-1 when LOAD_STAGE>3, forward non-load results only. The same priority scan is extended to k>=3, excluding loads.
- x0 never stalls or forwards.

Optional Feature:
CORE_PIPE_PERF_EN
- Defined: adds outputs perf_stall_cyc_o[31:0] and perf_flush_cnt_o[31:0].
  - perf_stall_cyc_o counts cycles with mem_stall_i or an effective load-use stall.
  - perf_flush_cnt_o counts accepted redirects.
  - Both cleared by reset, saturate at 32'hFFFF_FFFF.
- Undefined: ports absent, no counter flops.

Decomposition:
- Package core_pipe_pkg:
  - stage index constants STG_IF=0, STG_ID=1, STG_EX=2.
  - function fwd_sel_w(n) returning $clog2(n).
  - typedef reg_addr_t (logic [REG_ADDR_W-1:0]).
- Sub-module core_fwd_unit: combinational priority scan, instantiated once per EX operand.

Test Plan:
1. Reset, then if_valid_i=1 for 6 cycles -> st_valid_o = 00001, 00011, ... 11111 (defaults); st_en_o=11111 throughout.
2. lw x5 in EX, ID add reads x5 -> ld_use_stall_o=1 for 1 cycle, st_en_o=11100, EX valid=0 next cycle; then fwd_rs1_o=4 (WB) for the add.
3. add x3 in MEM (stage 3), sub x3 in WB, EX reads x3 -> fwd_rs1_o=3. With rd=x0 in both -> fwd_rs1_o=0.
4. redirect_i=1 with stages 0-4 valid -> next st_valid_o=11000. Same cycle with a load-use hazard -> enables 11111, redirect wins.
5. mem_stall_i=1 for 3 cycles with redirect_i=1 -> valids frozen, st_en_o=0; redirect applied on the first cycle after release.
6. With CORE_PIPE_PERF_EN: scenarios 2+4+5 sequence -> perf_stall_cyc_o=4, perf_flush_cnt_o=2. Assert rstn mid-stall -> all valids 0 and counters 0 the next cycle.

Source files
------------

// File: rtl/core_pipe_pkg.sv
// +----------------------------------------------------------------------------+
// | core_pipe_pkg                                                              |
// | Shared stage indices, register-address type and helper function for the   |
// | RV32I pipeline control unit.                                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package core_pipe_pkg;

  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;

  localparam int RV_REG_ADDR_W = 5;

  typedef logic [RV_REG_ADDR_W-1:0] reg_addr_t;

  function automatic int fwd_sel_w(input int n);
    return $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_fwd_unit.sv
// +----------------------------------------------------------------------------+
// | core_fwd_unit                                                              |
// | Priority scan selecting the youngest later stage that can supply one EX    |
// | operand; flags a load caught at LOAD_STAGE (must not reach EX).            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module core_fwd_unit
  import core_pipe_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_STAGE = 3,
  parameter int SEL_W      = 3
) (
  input  logic [NUM_STAGES-1:0]            valid,
  input  logic [NUM_STAGES-1:0]            we,
  input  logic [NUM_STAGES-1:0]            ld,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0]            rs,
  output logic [SEL_W-1:0]                 sel,
  output logic                             illegal
);

  // Stages up to EX never act as forwarding sources.
  logic unused_low;
  assign unused_low = ^{valid[STG_EX:0], we[STG_EX:0], ld[STG_EX:0],
                        rd[(STG_EX+1)*REG_ADDR_W-1:0]};

  // Scan oldest to youngest so the youngest matching producer is kept last.
  always_comb begin
    sel     = '0;
    illegal = 1'b0;
    for (int k = NUM_STAGES - 1; k > STG_EX; k--) begin
      if (valid[k] && we[k] && (rs != '0) &&
          (rd[k*REG_ADDR_W +: REG_ADDR_W] == rs) &&
          ((k >= LOAD_STAGE) || !ld[k])) begin
        if ((k == LOAD_STAGE) && ld[k]) begin
          sel     = '0;
          illegal = 1'b1;
        end else begin
          sel     = SEL_W'(k);
          illegal = 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_pipe_ctrl.sv
// +----------------------------------------------------------------------------+
// | core_pipe_ctrl                                                             |
// | Pipeline valid tracking, stage enables, load-use stall, redirect flush,    |
// | memory freeze and EX forwarding selects. Optional CORE_PIPE_PERF_EN adds   |
// | saturating stall-cycle and flush counters.                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module core_pipe_ctrl
  import core_pipe_pkg::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int REG_ADDR_W  = 5,
  parameter int LOAD_STAGE  = 3,
  parameter int FLUSH_STAGE = 2,
  parameter int SEL_W       = fwd_sel_w(NUM_STAGES)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             if_valid_i,
  input  logic                             mem_stall_i,
  input  logic                             redirect_i,
  input  logic [REG_ADDR_W-1:0]            id_rs1_i,
  input  logic [REG_ADDR_W-1:0]            id_rs2_i,
  input  logic [1:0]                       id_rs_use_i,
  input  logic [REG_ADDR_W-1:0]            ex_rs1_i,
  input  logic [REG_ADDR_W-1:0]            ex_rs2_i,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] st_rd_i,
  input  logic [NUM_STAGES-1:0]            st_we_i,
  input  logic [NUM_STAGES-1:0]            st_ld_i,
  output logic [NUM_STAGES-1:0]            st_valid_o,
  output logic [NUM_STAGES-1:0]            st_en_o,
  output logic [SEL_W-1:0]                 fwd_rs1_o,
  output logic [SEL_W-1:0]                 fwd_rs2_o,
  output logic                             ld_use_stall_o
`ifdef CORE_PIPE_PERF_EN
  ,
  output logic [31:0]                      perf_stall_cyc_o,
  output logic [31:0]                      perf_flush_cnt_o
`endif
);

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_d;
  logic [NUM_STAGES-1:0] valid_adv;
  logic                  hazard;
  logic [1:0]            fwd_illegal;

  // IF and ID hazard fields are never producers for anything.
  logic unused_front;
  assign unused_front = ^{st_we_i[STG_ID:STG_IF], st_ld_i[STG_ID:STG_IF],
                          st_rd_i[(STG_ID+1)*REG_ADDR_W-1:0]};

  // A load still between EX and LOAD_STAGE cannot yet feed the ID consumer.
  always_comb begin
    hazard = 1'b0;
    for (int j = STG_EX; j < LOAD_STAGE; j++) begin
      if (valid_q[j] && st_we_i[j] && st_ld_i[j] &&
          (st_rd_i[j*REG_ADDR_W +: REG_ADDR_W] != '0)) begin
        if (id_rs_use_i[0] && (id_rs1_i == st_rd_i[j*REG_ADDR_W +: REG_ADDR_W]))
          hazard = 1'b1;
        if (id_rs_use_i[1] && (id_rs2_i == st_rd_i[j*REG_ADDR_W +: REG_ADDR_W]))
          hazard = 1'b1;
      end
    end
    hazard = hazard & valid_q[STG_ID];
  end

  assign valid_adv = {valid_q[NUM_STAGES-2:0], if_valid_i};

  always_comb begin
    valid_d = valid_q;
    st_en_o = '1;
    if (mem_stall_i) begin
      st_en_o = '0;
    end else if (redirect_i) begin
      valid_d                = valid_adv;
      valid_d[FLUSH_STAGE:0] = '0;
    end else if (hazard) begin
      valid_d                = valid_adv;
      valid_d[STG_ID:STG_IF] = valid_q[STG_ID:STG_IF];
      valid_d[STG_EX]        = 1'b0;
      st_en_o[STG_ID:STG_IF] = '0;
    end else begin
      valid_d = valid_adv;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  assign st_valid_o     = valid_q;
  assign ld_use_stall_o = hazard;

  core_fwd_unit #(
    .NUM_STAGES (NUM_STAGES),
    .REG_ADDR_W (REG_ADDR_W),
    .LOAD_STAGE (LOAD_STAGE),
    .SEL_W      (SEL_W)
  ) u_fwd_rs1 (
    .valid   (valid_q),
    .we      (st_we_i),
    .ld      (st_ld_i),
    .rd      (st_rd_i),
    .rs      (ex_rs1_i),
    .sel     (fwd_rs1_o),
    .illegal (fwd_illegal[0])
  );

  core_fwd_unit #(
    .NUM_STAGES (NUM_STAGES),
    .REG_ADDR_W (REG_ADDR_W),
    .LOAD_STAGE (LOAD_STAGE),
    .SEL_W      (SEL_W)
  ) u_fwd_rs2 (
    .valid   (valid_q),
    .we      (st_we_i),
    .ld      (st_ld_i),
    .rd      (st_rd_i),
    .rs      (ex_rs2_i),
    .sel     (fwd_rs2_o),
    .illegal (fwd_illegal[1])
  );

  // The load-use stall must keep a consumer out of EX until the load passes LOAD_STAGE.
  a_no_load_fwd_at_load_stage : assert property (
    @(posedge clk) disable iff (rstn) fwd_illegal == 2'b00
  );

`ifdef CORE_PIPE_PERF_EN
  logic [31:0] stall_cyc_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rstn) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((mem_stall_i || (hazard && !redirect_i)) && (stall_cyc_q != '1))
        stall_cyc_q <= stall_cyc_q + 32'd1;
      if (redirect_i && !mem_stall_i && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cyc_o = stall_cyc_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_pipe_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_core_pipe_ctrl                                                          |
// | Directed table-driven bench for core_pipe_ctrl at default parameters.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_core_pipe_ctrl;
  import core_pipe_pkg::*;

  localparam int NS = 5;
  localparam int RW = 5;
  localparam int NV = 27;

  logic            clk;
  logic            rstn;
  logic            if_valid;
  logic            mem_stall;
  logic            redirect;
  reg_addr_t       id_rs1, id_rs2, ex_rs1, ex_rs2;
  logic [1:0]      id_rs_use;
  logic [NS*RW-1:0] st_rd;
  logic [NS-1:0]   st_we, st_ld;
  logic [NS-1:0]   st_valid, st_en;
  logic [2:0]      fwd_rs1, fwd_rs2;
  logic            ld_use_stall;
`ifdef CORE_PIPE_PERF_EN
  logic [31:0]     perf_stall_cyc, perf_flush_cnt;
`endif

  core_pipe_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .if_valid_i     (if_valid),
    .mem_stall_i    (mem_stall),
    .redirect_i     (redirect),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_rs_use_i    (id_rs_use),
    .ex_rs1_i       (ex_rs1),
    .ex_rs2_i       (ex_rs2),
    .st_rd_i        (st_rd),
    .st_we_i        (st_we),
    .st_ld_i        (st_ld),
    .st_valid_o     (st_valid),
    .st_en_o        (st_en),
    .fwd_rs1_o      (fwd_rs1),
    .fwd_rs2_o      (fwd_rs2),
    .ld_use_stall_o (ld_use_stall)
`ifdef CORE_PIPE_PERF_EN
    ,
    .perf_stall_cyc_o (perf_stall_cyc),
    .perf_flush_cnt_o (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            ifv, ms, rdr;
    reg_addr_t       id1, id2;
    logic [1:0]      rsuse;
    reg_addr_t       ex1, ex2;
    logic [NS*RW-1:0] rd;
    logic [NS-1:0]   we, ld;
    logic [NS-1:0]   e_valid, e_en;
    logic [2:0]      e_f1, e_f2;
    logic            e_stall;
  } vec_t;

  vec_t vecs [NV];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  function automatic logic [NS*RW-1:0] rdv(input int r2, input int r3, input int r4);
    return {RW'(r4), RW'(r3), RW'(r2), RW'(0), RW'(0)};
  endfunction

  function automatic vec_t mk(input logic ifv, ms, rdr, input int id1, id2,
                              input logic [1:0] rsuse, input int ex1, ex2,
                              input logic [NS*RW-1:0] rd, input logic [NS-1:0] we, ld,
                              input logic [NS-1:0] ev, een, input int f1, f2,
                              input logic st);
    vec_t v;
    v.ifv = ifv; v.ms = ms; v.rdr = rdr;
    v.id1 = RW'(id1); v.id2 = RW'(id2); v.rsuse = rsuse;
    v.ex1 = RW'(ex1); v.ex2 = RW'(ex2);
    v.rd = rd; v.we = we; v.ld = ld;
    v.e_valid = ev; v.e_en = een;
    v.e_f1 = 3'(f1); v.e_f2 = 3'(f2); v.e_stall = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    //                ifv ms rdr id1 id2 use    ex1 ex2 rd            we        ld        valid     en        f1 f2 stall
    vecs[0]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b11111, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b00001, 5'b11111, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b00011, 5'b11111, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b00111, 5'b11111, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b01111, 5'b11111, 0, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b11111, 5'b11111, 0, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b11111, 5'b11111, 0, 0, 0);
    // lw x5 in EX, ID reads x5: one bubble, then forward from WB
    vecs[7]  = mk(1, 0, 0, 5, 0, 2'b01, 0, 0, rdv(5,0,0), 5'b00100, 5'b00100, 5'b11111, 5'b11100, 0, 0, 1);
    vecs[8]  = mk(1, 0, 0, 5, 0, 2'b01, 0, 0, rdv(0,5,0), 5'b01000, 5'b01000, 5'b11011, 5'b11111, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0, 0, 0, 2'b00, 5, 0, rdv(0,0,5), 5'b10000, 5'b10000, 5'b10111, 5'b11111, 4, 0, 0);
    // invalid WB stage must not forward
    vecs[10] = mk(1, 0, 0, 0, 0, 2'b00, 3, 0, rdv(0,0,3), 5'b10000, 5'b00000, 5'b01111, 5'b11111, 0, 0, 0);
    vecs[11] = mk(1, 0, 0, 0, 0, 2'b00, 3, 0, rdv(0,3,3), 5'b11000, 5'b00000, 5'b11111, 5'b11111, 3, 0, 0);
    vecs[12] = mk(1, 0, 0, 0, 0, 2'b01, 0, 0, rdv(0,0,0), 5'b11100, 5'b00100, 5'b11111, 5'b11111, 0, 0, 0);
    vecs[13] = mk(1, 0, 0, 1, 6, 2'b01, 9, 9, rdv(6,9,9), 5'b10100, 5'b00100, 5'b11111, 5'b11111, 4, 4, 0);
    // redirect with simultaneous rs2 load-use hazard
    vecs[14] = mk(1, 0, 1, 0, 6, 2'b10, 0, 0, rdv(6,0,0), 5'b00100, 5'b00100, 5'b11111, 5'b11111, 0, 0, 1);
    vecs[15] = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b11000, 5'b11111, 0, 0, 0);
    vecs[16] = mk(1, 1, 1, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b10001, 5'b00000, 0, 0, 0);
    vecs[17] = mk(1, 1, 1, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b10001, 5'b00000, 0, 0, 0);
    vecs[18] = mk(1, 1, 1, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b10001, 5'b00000, 0, 0, 0);
    vecs[19] = mk(1, 0, 1, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b10001, 5'b11111, 0, 0, 0);
    vecs[20] = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b11111, 0, 0, 0);
    vecs[21] = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b00001, 5'b11111, 0, 0, 0);
    vecs[22] = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b00011, 5'b11111, 0, 0, 0);
    // hazard visible under mem stall, then acted on once released
    vecs[23] = mk(1, 1, 0, 5, 0, 2'b01, 0, 0, rdv(5,0,0), 5'b00100, 5'b00100, 5'b00111, 5'b00000, 0, 0, 1);
    vecs[24] = mk(1, 0, 0, 5, 0, 2'b01, 0, 0, rdv(5,0,0), 5'b00100, 5'b00100, 5'b00111, 5'b11100, 0, 0, 1);
    vecs[25] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b01011, 5'b11111, 0, 0, 0);
    vecs[26] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, rdv(0,0,0), 5'b00000, 5'b00000, 5'b10110, 5'b11111, 0, 0, 0);

    rstn = 1'b1; if_valid = 1'b0; mem_stall = 1'b0; redirect = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rs_use = '0; ex_rs1 = '0; ex_rs2 = '0;
    st_rd = '0; st_we = '0; st_ld = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("reset valid", 32'(st_valid), 32'h0);
    chk("reset en", 32'(st_en), 32'h1f);
`ifdef CORE_PIPE_PERF_EN
    chk("reset perf_stall", perf_stall_cyc, 32'd0);
    chk("reset perf_flush", perf_flush_cnt, 32'd0);
`endif

    for (int i = 0; i < NV; i++) begin
      if_valid = vecs[i].ifv; mem_stall = vecs[i].ms; redirect = vecs[i].rdr;
      id_rs1 = vecs[i].id1; id_rs2 = vecs[i].id2; id_rs_use = vecs[i].rsuse;
      ex_rs1 = vecs[i].ex1; ex_rs2 = vecs[i].ex2;
      st_rd = vecs[i].rd; st_we = vecs[i].we; st_ld = vecs[i].ld;
      #1;
      chk($sformatf("v%0d valid", i), 32'(st_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d en", i), 32'(st_en), 32'(vecs[i].e_en));
      chk($sformatf("v%0d fwd_rs1", i), 32'(fwd_rs1), 32'(vecs[i].e_f1));
      chk($sformatf("v%0d fwd_rs2", i), 32'(fwd_rs2), 32'(vecs[i].e_f2));
      chk($sformatf("v%0d ld_use_stall", i), 32'(ld_use_stall), 32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
    end

`ifdef CORE_PIPE_PERF_EN
    chk("perf_stall total", perf_stall_cyc, 32'd6);
    chk("perf_flush total", perf_flush_cnt, 32'd2);
`endif

    // Reset asserted in the middle of a memory stall
    mem_stall = 1'b1;
    #1;
    chk("pre-reset valid", 32'(st_valid), 32'h0c);
    chk("stalled en", 32'(st_en), 32'h00);
    rstn = 1'b1;
    @(posedge clk);
    #1 rstn = 1'b0;
    chk("mid-stall reset valid", 32'(st_valid), 32'h0);
`ifdef CORE_PIPE_PERF_EN
    chk("mid-stall reset perf_stall", perf_stall_cyc, 32'd0);
    chk("mid-stall reset perf_flush", perf_flush_cnt, 32'd0);
`endif
    mem_stall = 1'b0;
    #1;
    chk("released en", 32'(st_en), 32'h1f);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
